// File: rtl/err_compute_if.sv
// err_compute_if: bundle between the IR mux / trigger source and the
// error-compute sequencer.
//   IR_vld  : start or restart request, one per cycle
//   ch_en   : per-channel enable mask, captured when a request is accepted
//   ir_data : mux output for the channel currently selected by sel
//   sel     : IR mux select
//   busy    : high while a pass is running, including the result cycle
//   err     : signed saturated error, held between updates
//   err_vld : one-cycle pulse, err has just been updated
// The slave modport is the sequencer. The master modport is the
// surrounding system, which provides the mux and the trigger.
interface err_compute_if #(
  parameter int NUM_CH = 8,
  parameter int DW     = 12,
  parameter int OUT_W  = 16
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic              IR_vld;
  logic [NUM_CH-1:0] ch_en;
  logic [DW-1:0]     ir_data;
  logic [SEL_W-1:0]  sel;
  logic              busy;
  logic [OUT_W-1:0]  err;
  logic              err_vld;

  modport slave (
    input  IR_vld, ch_en, ir_data,
    output sel, busy, err, err_vld
  );

  modport master (
    output IR_vld, ch_en, ir_data,
    input  sel, busy, err, err_vld
  );
endinterface

// File: rtl/err_compute_seq.sv
// err_compute_seq: for each accepted IR_vld, steps the IR mux select through
// every channel and accumulates signed, weighted readings.
//   Channels below HALF add (x << i).
//   Channels at or above HALF subtract (x << (i-HALF)).
// When the pass finishes, it presents the saturated sum on err together
// with a one-cycle err_vld pulse.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : err_compute_if slave. Carries IR_vld, ch_en, ir_data in and
//         sel, busy, err, err_vld out.
module err_compute_seq #(
  parameter int NUM_CH = 8,
  parameter int DW     = 12,
  parameter int OUT_W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  err_compute_if.slave  bus
);
  localparam int HALF  = NUM_CH / 2;
  localparam int SEL_W = $clog2(NUM_CH);
  localparam int ACC_W = DW + HALF + 1;

  // Clamp limits, sign-extended to the accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                   state_reg, state_next;
  logic [SEL_W-1:0]         cnt_reg, cnt_next;
  logic signed [ACC_W-1:0]  acc_reg, acc_next;
  logic [NUM_CH-1:0]        mask_reg, mask_next;
  logic [OUT_W-1:0]         err_reg, err_next;

  logic signed [ACC_W-1:0]  acc_sum;
  logic [SEL_W-1:0]         sel;
  logic                     busy;
  logic                     err_vld;

  // The sample is zero-extended before shifting. Negation then happens at
  // the full accumulator width, so the shift cannot flip the sign.
  logic [ACC_W-1:0]         ir_ext;
  logic signed [ACC_W-1:0]  term [NUM_CH];

  assign ir_ext = {{(ACC_W-DW){1'b0}}, bus.ir_data};

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_term
    if (gi < HALF) begin : g_pos
      assign term[gi] = ir_ext << gi;
    end else begin : g_neg
      assign term[gi] = -(ir_ext << (gi - HALF));
    end
  end

  function automatic logic [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] a);
    if (a > SAT_MAX)      sat = SAT_MAX[OUT_W-1:0];
    else if (a < SAT_MIN) sat = SAT_MIN[OUT_W-1:0];
    else                  sat = a[OUT_W-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      mask_reg  <= '0;
      err_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      acc_reg   <= acc_next;
      mask_reg  <= mask_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    acc_next   = acc_reg;
    mask_next  = mask_reg;
    err_next   = err_reg;
    acc_sum    = acc_reg;
    sel        = '0;
    busy       = 1'b0;
    err_vld    = 1'b0;

    // Masked channels still take a cycle, so latency does not depend on
    // ch_en.
    if (mask_reg[cnt_reg]) acc_sum = acc_reg + term[cnt_reg];

    case (state_reg)
      IDLE: begin
        if (bus.IR_vld) begin
          acc_next   = '0;
          cnt_next   = '0;
          mask_next  = bus.ch_en;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        busy = 1'b1;
        sel  = cnt_reg;
        if (bus.IR_vld) begin
          // Retrigger: drop the partial pass and start over.
          acc_next  = '0;
          cnt_next  = '0;
          mask_next = bus.ch_en;
        end else begin
          acc_next = acc_sum;
          cnt_next = cnt_reg + SEL_W'(1);
          if (cnt_reg == SEL_W'(NUM_CH - 1)) begin
            // Load err on the edge entering DONE, so that err and err_vld
            // become valid in the same cycle.
            err_next   = sat(acc_sum);
            cnt_next   = '0;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        busy    = 1'b1;
        err_vld = 1'b1;
        if (bus.IR_vld) begin
          acc_next   = '0;
          cnt_next   = '0;
          mask_next  = bus.ch_en;
          state_next = ACCUM;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.sel     = sel;
  assign bus.busy    = busy;
  assign bus.err     = err_reg;
  assign bus.err_vld = err_vld;
endmodule

// File: tb/tb_err_compute_seq.sv
module tb_err_compute_seq;
  localparam int NUM_CH = 8;
  localparam int DW     = 12;
  localparam int OUT_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  err_compute_if #(.NUM_CH(NUM_CH), .DW(DW), .OUT_W(OUT_W)) bus ();

  err_compute_seq #(.NUM_CH(NUM_CH), .DW(DW), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Model of the external IR mux.
  logic [DW-1:0] ir_mem [NUM_CH];
  assign bus.ir_data = ir_mem[bus.sel];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [OUT_W-1:0] exp_err_q [$];
  int               exp_cyc_q [$];

  function automatic logic [OUT_W-1:0] model(input logic [NUM_CH-1:0] m);
    int s;
    logic [31:0] r;
    s = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (m[i]) begin
        if (i < NUM_CH/2) s = s + int'(ir_mem[i]) * (2 ** i);
        else              s = s - int'(ir_mem[i]) * (2 ** (i - NUM_CH/2));
      end
    end
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    r = 32'(s);
    return r[OUT_W-1:0];
  endfunction

  // Scoreboard: each err_vld pulse must match the oldest expected result,
  // both in value and in cycle.
  always @(negedge clk) begin
    if (bus.err_vld === 1'b1) begin
      vectors++;
      if (exp_err_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_err_vld: cycle %0d err=%0d, required no pulse", cyc, $signed(bus.err));
      end else begin
        logic [OUT_W-1:0] e;
        int c;
        e = exp_err_q.pop_front();
        c = exp_cyc_q.pop_front();
        if (bus.err !== e || cyc != c) begin
          errors++;
          $display("FAIL result: err=%0d at cycle %0d, required %0d at cycle %0d",
                   $signed(bus.err), cyc, $signed(e), c);
        end else begin
          $display("result ok: err=%0d at cycle %0d", $signed(bus.err), cyc);
        end
      end
    end
  end

  task automatic set_ir(input logic [DW-1:0] lo, input logic [DW-1:0] hi);
    for (int i = 0; i < NUM_CH; i++) ir_mem[i] = (i < NUM_CH/2) ? lo : hi;
  endtask

  // Pulses IR_vld for one cycle and queues the expected result.
  // On return the caller is at the negedge of cycle c+1, where sel is 0.
  task automatic pulse(input logic [NUM_CH-1:0] m, output int c);
    @(negedge clk);
    bus.ch_en  = m;
    bus.IR_vld = 1'b1;
    c = cyc;
    exp_err_q.push_back(model(m));
    exp_cyc_q.push_back(c + NUM_CH + 1);
    @(negedge clk);
    bus.IR_vld = 1'b0;
  endtask

  task automatic run(input logic [NUM_CH-1:0] m);
    int c;
    pulse(m, c);
    repeat (NUM_CH + 2) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string name);
    vectors++;
    if (bus.sel !== '0 || bus.busy !== 1'b0 || bus.err !== '0 || bus.err_vld !== 1'b0) begin
      errors++;
      $display("FAIL %s: sel=%0d busy=%b err=%0d err_vld=%b, required all zero",
               name, bus.sel, bus.busy, $signed(bus.err), bus.err_vld);
    end else $display("%s ok", name);
  endtask

  task automatic test_reset();
    bus.IR_vld = 1'b0;
    bus.ch_en  = '0;
    set_ir('0, '0);
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_state");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_balanced();
    int c;
    set_ir(12'h100, 12'h100);
    pulse(8'hFF, c);
    bus.ch_en = 8'h00;  // changed while busy; must be ignored
    for (int k = 0; k < NUM_CH; k++) begin
      vectors++;
      if (bus.sel !== 3'(k) || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL sel_step: sel=%0d busy=%b, required sel=%0d busy=1", bus.sel, bus.busy, k);
      end
      @(negedge clk);
    end
    vectors++;
    if (bus.err_vld !== 1'b1 || bus.busy !== 1'b1 || bus.sel !== '0) begin
      errors++;
      $display("FAIL done_cycle: err_vld=%b busy=%b sel=%0d, required 1 1 0", bus.err_vld, bus.busy, bus.sel);
    end else $display("done_cycle ok at cycle %0d", cyc);
    @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || bus.err !== 16'd0) begin
      errors++;
      $display("FAIL after_done: busy=%b err=%0d, required 0 0", bus.busy, $signed(bus.err));
    end else $display("after_done ok");
  endtask

  task automatic test_saturation();
    set_ir(12'hFFF, 12'h000);
    run(8'hFF);
    vectors++;
    if (bus.err !== 16'h7FFF) begin
      errors++;
      $display("FAIL err_held: err=%0d, required 32767", $signed(bus.err));
    end else $display("err_held ok");
    set_ir(12'h000, 12'hFFF);
    run(8'hFF);
  endtask

  task automatic test_mask();
    set_ir(12'h010, 12'h010);
    run(8'h10);
    run(8'h08);
    run(8'h00);
    set_ir(12'h123, 12'h0AB);
    run(8'h5A);
  endtask

  task automatic test_restart();
    int c;
    set_ir(12'h300, 12'h001);
    @(negedge clk);
    bus.ch_en  = 8'hFF;
    bus.IR_vld = 1'b1;
    @(negedge clk);
    bus.IR_vld = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (bus.sel !== 3'd5) begin
      errors++;
      $display("FAIL restart_pre: sel=%0d, required 5", bus.sel);
    end
    // Change the data and retrigger in this cycle (sel=5).
    set_ir(12'h002, 12'h040);
    bus.ch_en  = 8'hF3;
    bus.IR_vld = 1'b1;
    c = cyc;
    exp_err_q.push_back(model(8'hF3));
    exp_cyc_q.push_back(c + NUM_CH + 1);
    @(negedge clk);
    bus.IR_vld = 1'b0;
    vectors++;
    if (bus.sel !== '0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_sel: sel=%0d busy=%b, required 0 1", bus.sel, bus.busy);
    end else $display("restart_sel ok");
    repeat (NUM_CH + 2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int c;
    set_ir(12'h050, 12'h020);
    pulse(8'hFF, c);
    repeat (NUM_CH) @(negedge clk);  // now in the DONE cycle
    set_ir(12'h007, 12'h200);
    bus.ch_en  = 8'hF0;
    bus.IR_vld = 1'b1;
    exp_err_q.push_back(model(8'hF0));
    exp_cyc_q.push_back(cyc + NUM_CH + 1);
    @(negedge clk);
    bus.IR_vld = 1'b0;
    vectors++;
    if (bus.sel !== '0 || bus.busy !== 1'b1 || bus.err_vld !== 1'b0) begin
      errors++;
      $display("FAIL b2b_next: sel=%0d busy=%b err_vld=%b, required 0 1 0", bus.sel, bus.busy, bus.err_vld);
    end else $display("b2b_next ok");
    repeat (NUM_CH + 2) @(negedge clk);
  endtask

  task automatic test_held();
    int bad;
    bad = 0;
    set_ir(12'h011, 12'h000);
    @(negedge clk);
    bus.ch_en  = 8'h0F;
    bus.IR_vld = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.sel !== '0 || bus.busy !== 1'b1 || bus.err_vld !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL held: %0d cycles with sel/busy/err_vld off, required 0", bad);
    end else $display("held ok");
    exp_err_q.push_back(model(8'h0F));
    exp_cyc_q.push_back(cyc + NUM_CH + 1);
    @(negedge clk);
    bus.IR_vld = 1'b0;
    repeat (NUM_CH + 2) @(negedge clk);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.ch_en  = 8'hFF;
    bus.IR_vld = 1'b1;
    @(negedge clk);
    bus.IR_vld = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.sel !== 3'd3) begin
      errors++;
      $display("FAIL rst_pre: sel=%0d, required 3", bus.sel);
    end
    #1 rst = 1'b1;
    #1 check_idle_outputs("async_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (NUM_CH + 4) @(negedge clk);  // scoreboard flags any stray pulse
    set_ir(12'h0C0, 12'h033);
    run(8'hFF);
  endtask

  initial begin
    test_reset();
    test_balanced();
    test_saturation();
    test_mask();
    test_restart();
    test_back_to_back();
    test_held();
    test_async_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if (exp_err_q.size() != 0) begin
      errors++;
      $display("FAIL missing_results: %0d pending, required 0", exp_err_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/err_compute_seq.md
Name: err_compute_seq

Overview:
- Parametrised successor to the IR error-compute sequencer. Adds an integrated signed-weighted accumulator, a configurable channel count, a per-channel enable mask, output saturation and restart-on-retrigger.
- On each IR_vld it steps the external IR mux through all channels via sel and accumulates the weighted readings. It then presents a saturated signed error with a one-cycle err_vld pulse to the PID stage.
- Sits between the IR sensor mux and the steering controller.

Parameters:
- NUM_CH, 8, channel count. Even, ≥2. HALF = NUM_CH/2.
- DW, 12, unsigned IR sample width.
- OUT_W, 16, signed width of the err output. ≤ ACC_W.
- Localparams:
  - SEL_W = $clog2(NUM_CH).
  - ACC_W = DW + HALF + 1, signed accumulator width.

Ports:
- clk      input   1          system clock, rising edge.
- rst      input   1          reset.
- IR_vld   input   1          start/restart request, sampled every cycle.
- ch_en    input   NUM_CH     channel enable mask, captured on accepted IR_vld.
- ir_data  input   DW         mux output for the channel currently on sel.
- sel      output  SEL_W      IR mux select.
- busy     output  1          high while sequencing.
- err      output  OUT_W      signed saturated error, held between updates.
- err_vld  output  1          one-cycle pulse, err updated.

Interface note: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (async, rst=1): state=IDLE, cnt=0, acc=0, mask=0, sel=0, busy=0, err=0, err_vld=0. Takes effect immediately, including mid-sequence. No err_vld is produced for an aborted sequence.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - sel=0, busy=0.
  - If IR_vld: acc←0, cnt←0, mask←ch_en, go to ACCUM.
- ACCUM:
  - busy=1, sel=cnt.
  - Each cycle, if mask[cnt], acc←acc+term(cnt, ir_data); otherwise acc is unchanged. sel still steps, so latency is fixed regardless of mask.
  - cnt increments each cycle. After the cnt==NUM_CH-1 update, go to DONE.
- Weighting, term(i,x):
  - i<HALF: +(x << i).
  - i≥HALF: −(x << (i−HALF)).
  - Shifts are done zero-extended to ACC_W before negation. ACC_W guarantees no accumulator overflow.
- DONE:
  - err←sat(acc): clamp to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - err_vld=1 for exactly this cycle; busy=1; sel=0. Then go to IDLE.
  - err is registered, so it becomes valid in the same cycle err_vld is high and is held until the next DONE.
- Latency: IR_vld accepted at edge T0 gives sel=0..NUM_CH−1 on cycles 1..NUM_CH, and err_vld on cycle NUM_CH+1.
- ir_data timing: ir_data must be valid combinationally for the sel value presented in the same cycle. It is sampled on the edge ending that cycle.
- IR_vld during ACCUM: abort and restart. acc←0, cnt←0, mask←ch_en, stay in ACCUM. No err_vld for the aborted pass.
- IR_vld during DONE: err_vld still pulses with the completed result, and the next state is ACCUM with a fresh clear (no IDLE cycle).
- IR_vld held high continuously: restarts every cycle, never completes. This is legitimate; the bench checks it.
- ch_en changes while busy: ignored until the next accepted IR_vld.
- mask all-zero: err=0 with a normal err_vld pulse.

Test Plan:
- Balanced input (NUM_CH=8, DW=12, OUT_W=16), ch_en=0xFF, all ir=0x100 → err_vld at cycle 9 after IR_vld, err=0, sel sequence 0..7 observed.
- Left saturation: ir=0xFFF on ch0–3, 0 elsewhere → raw 61425 clamps, err=32767. Mirror on ch4–7 → err=−32768.
- Mask and weights: ch_en=0x10, all ir=0x010 → err=−16. Then ch_en=0x08, ir=0x010 → err=+128. Latency is still 9 cycles.
- Restart: IR_vld re-pulsed at sel=5 → sel restarts at 0, a single err_vld fires 9 cycles after the second pulse, and the result reflects only the second pass.
- Back-to-back: IR_vld asserted in the DONE cycle → err_vld pulses, next cycle sel=0 with busy=1, and the second result is correct.
- Async reset: rst asserted at sel=3 between clock edges → outputs go to reset values immediately and no err_vld follows. A post-reset IR_vld sequences normally.
